if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: stall  in  1  hazard-unit hold request; the fetched instruction must not advance.
REQ-004 SHALL have ports: branch_jump_signal  in  1  taken branch/jump redirect from EX.
REQ-005 SHALL have ports: branch_target  in  32  redirect address.
REQ-006 SHALL have ports: imem_busywait  in  1  instruction cache busy; readdata is valid when low.
REQ-007 SHALL have ports: imem_readdata  in  32  instruction word from cache.
REQ-008 SHALL have ports: imem_read  out  1  cache read request.
REQ-009 SHALL have ports: imem_address  out  32  cache word address.
REQ-010 SHALL have ports: pc_out, pc_4_out, instr_out  out  32 each  IF/ID register inputs.
REQ-011 SHALL have ports: fetch_busywait  out  1  high = IF/ID register must not capture this cycle.

Function
REQ-012 SHALL use three states: FETCH (request outstanding), HOLD (instruction buffered under stall) and FLUSH (redirect arrived while an access is in flight).
REQ-013 SHALL hold registers pc, redirect_pc and instr_buf, all 32 bits; imem_address = pc in every state.
REQ-014 SHALL drive imem_read = 1 in FETCH and FLUSH and 0 in HOLD.
REQ-015 SHALL drive pc_out = pc and pc_4_out = pc + 4, modulo 2^32 with no carry-out; PC 0xFFFFFFFC wraps to 0x00000000.
REQ-016 SHALL drive instr_out = instr_buf in HOLD and imem_readdata otherwise.
REQ-017 SHALL drive fetch_busywait as: FETCH: imem_busywait | stall | branch_jump_signal; HOLD: stall | branch_jump_signal; FLUSH: 1.
REQ-018 SHALL, in FETCH with imem_busywait=0, stall=0 and no branch, set pc <= pc+4 and stay in FETCH, giving one instruction per cycle on cache hits.
REQ-019 SHALL, in FETCH with imem_busywait=0 and stall=1, capture instr_buf <= imem_readdata and go to HOLD with pc unchanged.
REQ-020 SHALL, in HOLD when stall falls, present instr_buf with fetch_busywait=0 for exactly one cycle, then set pc <= pc+4 and go to FETCH.
REQ-021 SHALL let a branch have priority over stall and over a completing access: in FETCH with imem_busywait=0, or in HOLD, it SHALL set pc <= {branch_target[31:2],2'b00} and go to FETCH, discarding the current word and buffer.
REQ-022 SHALL, on a branch in FETCH with imem_busywait=1, latch redirect_pc <= aligned target and go to FLUSH, keeping imem_address stable.
REQ-023 SHALL, in FLUSH, overwrite redirect_pc with any newer branch target, so the latest branch wins.
REQ-024 SHALL, in FLUSH when imem_busywait=0, discard imem_readdata, set pc <= redirect_pc and go to FETCH.
REQ-025 SHALL keep imem_address constant while imem_busywait=1 in any state.
REQ-026 SHALL force branch_target[1:0] to zero; no misalignment trap is raised here.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, set pc=0, redirect_pc=0, instr_buf=0 and state=FETCH, overriding all other inputs.
REQ-028 SHALL, in the first cycle after reset, present imem_read=1, imem_address=0x00000000, pc_4_out=0x00000004 and fetch_busywait equal to the REQ-017 FETCH value.
REQ-029 SHALL abandon any in-flight access, buffered instruction or pending redirect on reset mid-operation, and SHALL NOT return to FLUSH.

Structure
REQ-030 SHALL take from the shared pipeline package: the state enum, RESET_PC = 32'h0 and PC_INCR = 32'd4.
REQ-031 SHALL be a single module with no sub-module; the pc+4 adder is inline and is also reused for pc_4_out.

Verification
REQ-032 SHALL cover: reset, then cache always hits -> addresses 0,4,8,C on consecutive cycles and fetch_busywait=0 each cycle.
REQ-033 SHALL cover: hit at pc=0x8 with stall=1 for 3 cycles -> HOLD, imem_read=0, instr_out = captured word; stall falls -> one valid cycle at pc=0x8, then address 0xC.
REQ-034 SHALL cover: branch to 0x100 while imem_busywait=1 at pc=0x10 -> address stays 0x10 until busy falls, the word is discarded, and the next address is 0x100.
REQ-035 SHALL cover: in FLUSH, a second branch to 0x200 after one to 0x100 -> the next fetch address is 0x200.
REQ-036 SHALL cover: branch to 0x40 in the same cycle as a hit and stall=1 -> no HOLD, next address 0x40, fetch_busywait=1 that cycle.
REQ-037 SHALL cover: reset asserted in HOLD and in FLUSH -> next cycle state FETCH, address 0x0, instr_buf cleared.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: fetch FSM states,
// reset/increment constants and the branch-target alignment helper.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StFlush = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR  = 32'd4;

    // Low two bits are dropped rather than trapped; misalignment is handled elsewhere.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the I-cache, buffers a word across hazard stalls and
// defers branch redirects that arrive while a cache access is still in flight.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_jump_signal,
    input  logic [31:0] branch_target,
    input  logic        imem_busywait,
    input  logic [31:0] imem_readdata,
    output logic        imem_read,
    output logic [31:0] imem_address,
    output logic [31:0] pc_out,
    output logic [31:0] pc_4_out,
    output logic [31:0] instr_out,
    output logic        fetch_busywait
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]  instr_buf_q, instr_buf_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  target_aligned;

    // Single adder serves both the sequential next PC and pc_4_out.
    assign pc_plus4       = pc_q + PC_INCR;
    assign target_aligned = align_pc(branch_target);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            instr_buf_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            instr_buf_q   <= instr_buf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        instr_buf_d   = instr_buf_q;

        unique case (state_q)
            StFetch: begin
                if (imem_busywait) begin
                    // Address must stay put until the cache finishes; park the redirect.
                    if (branch_jump_signal) begin
                        redirect_pc_d = target_aligned;
                        state_d       = StFlush;
                    end
                end else if (branch_jump_signal) begin
                    pc_d = target_aligned;
                end else if (stall) begin
                    instr_buf_d = imem_readdata;
                    state_d     = StHold;
                end else begin
                    pc_d = pc_plus4;
                end
            end

            StHold: begin
                if (branch_jump_signal) begin
                    pc_d    = target_aligned;
                    state_d = StFetch;
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = StFetch;
                end
            end

            StFlush: begin
                if (branch_jump_signal) begin
                    redirect_pc_d = target_aligned;
                end
                if (!imem_busywait) begin
                    // A branch arriving on the completing cycle is the newest one.
                    pc_d    = branch_jump_signal ? target_aligned : redirect_pc_q;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_comb begin
        imem_read      = 1'b1;
        instr_out      = imem_readdata;
        fetch_busywait = 1'b1;

        unique case (state_q)
            StFetch: begin
                fetch_busywait = imem_busywait | stall | branch_jump_signal;
            end
            StHold: begin
                imem_read      = 1'b0;
                instr_out      = instr_buf_q;
                fetch_busywait = stall | branch_jump_signal;
            end
            StFlush: begin
                fetch_busywait = 1'b1;
            end
            default: begin
                fetch_busywait = 1'b1;
            end
        endcase
    end

    assign imem_address = pc_q;
    assign pc_out       = pc_q;
    assign pc_4_out     = pc_plus4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit: hit streaming, stall hold, deferred
// and chained redirects, branch priority, mid-operation reset and PC wrap.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_jump_signal;
    logic [31:0] branch_target;
    logic        imem_busywait;
    logic [31:0] imem_readdata;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] pc_out;
    logic [31:0] pc_4_out;
    logic [31:0] instr_out;
    logic        fetch_busywait;

    int checks   = 0;
    int failures = 0;

    if_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_jump_signal(branch_jump_signal),
        .branch_target     (branch_target),
        .imem_busywait     (imem_busywait),
        .imem_readdata     (imem_readdata),
        .imem_read         (imem_read),
        .imem_address      (imem_address),
        .pc_out            (pc_out),
        .pc_4_out          (pc_4_out),
        .instr_out         (instr_out),
        .fetch_busywait    (fetch_busywait)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic br, input logic [31:0] tgt,
                         input logic busy, input logic [31:0] rdata);
        stall              = s;
        branch_jump_signal = br;
        branch_target      = tgt;
        imem_busywait      = busy;
        imem_readdata      = rdata;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // First cycle after reset
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h1111_0000);
        check("rst_read", imem_read, 32'd1);
        check("rst_addr", imem_address, 32'h0);
        check("rst_pc4", pc_4_out, 32'h4);
        check("rst_fbw", fetch_busywait, 32'd0);

        // Hit stream 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h1111_0000 + 32'(i));
            check("hit_addr", imem_address, 32'(i * 4));
            check("hit_fbw", fetch_busywait, 32'd0);
            check("hit_instr", instr_out, 32'h1111_0000 + 32'(i));
            tick();
        end

        // Branch while busy at 0x10; misaligned target 0x103 aligns to 0x100
        drive(1'b0, 1'b1, 32'h0000_0103, 1'b1, 32'hBAD0_0000);
        check("bbusy_addr", imem_address, 32'h10);
        check("bbusy_fbw", fetch_busywait, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0001);
        check("flush_addr", imem_address, 32'h10);
        check("flush_read", imem_read, 32'd1);
        check("flush_fbw", fetch_busywait, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'hBAD0_0002);
        check("flush_done_addr", imem_address, 32'h10);
        check("flush_done_fbw", fetch_busywait, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h2222_0100);
        check("redir_addr", imem_address, 32'h100);
        check("redir_pc4", pc_4_out, 32'h104);
        check("redir_fbw", fetch_busywait, 32'd0);

        // Chained redirect in FLUSH: 0x100 then 0x200
        drive(1'b0, 1'b1, 32'h100, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h0);
        check("chain_addr", imem_address, 32'h100);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("chain_fbw", fetch_busywait, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("chain_addr2", imem_address, 32'h200);

        // Branch on a hit to 0x8
        drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
        check("bhit_fbw", fetch_busywait, 32'd1);
        tick();

        // Stall at 0x8 for three cycles
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'hA5A5_0008);
        check("st_addr", imem_address, 32'h8);
        check("st_fbw", fetch_busywait, 32'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
            check("hold_read", imem_read, 32'd0);
            check("hold_instr", instr_out, 32'hA5A5_0008);
            check("hold_fbw", fetch_busywait, 32'd1);
            check("hold_pc", pc_out, 32'h8);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        check("rel_fbw", fetch_busywait, 32'd0);
        check("rel_instr", instr_out, 32'hA5A5_0008);
        check("rel_pc", pc_out, 32'h8);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h3333_000C);
        check("post_addr", imem_address, 32'hC);
        check("post_read", imem_read, 32'd1);

        // Branch + hit + stall together: branch wins, no HOLD
        drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h3333_000C);
        check("prio_fbw", fetch_busywait, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("prio_addr", imem_address, 32'h40);
        check("prio_read", imem_read, 32'd1);

        // Branch out of HOLD
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h4444_0040);
        tick();
        drive(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        check("hbr_read", imem_read, 32'd0);
        check("hbr_fbw", fetch_busywait, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("hbr_addr", imem_address, 32'h80);
        check("hbr_state_read", imem_read, 32'd1);

        // Reset while in HOLD
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h5555_0080);
        tick();
        check("rh_pre_read", imem_read, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h6666_0000);
        check("rh_addr", imem_address, 32'h0);
        check("rh_read", imem_read, 32'd1);
        check("rh_instr", instr_out, 32'h6666_0000);
        check("rh_fbw", fetch_busywait, 32'd0);
        tick();

        // Reset while in FLUSH: pending redirect must be dropped
        drive(1'b0, 1'b1, 32'h300, 1'b1, 32'h0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rf_addr", imem_address, 32'h0);
        check("rf_fbw", fetch_busywait, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rf_next", imem_address, 32'h4);

        // PC wrap at the top of the address space
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_4_out, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_addr", imem_address, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
